// File: rtl/i2c_target_core.sv
// -----------------------------------------------------------------------------
// i2c_target_core
//
// I2C target protocol engine. It oversamples SCL/SDA with the system clock,
// decodes START, STOP, the address byte and the data bytes, and drives a
// byte-wide register interface toward the peripheral block. It never stretches
// the clock. SDA is open-drain: sda_o is tied low and sda_oe selects between
// pulling the line low and releasing it.
//
// Parameters
//   TARGET_ADDR  7-bit bus address this target answers to
//   AUTO_INC     non-zero: addr advances after every data byte written or read
//
// Ports
//   clk         system clock, at least 20x the SCL frequency
//   rst_n       synchronous reset, active-low
//   scl         raw SCL pin (asynchronous)
//   sda_i       raw SDA pin (asynchronous)
//   sda_o       SDA output value, always 0
//   sda_oe      1 = pull SDA low (ACK or a 0 data bit)
//   rw          R/W bit of the last matching address byte (1 = read)
//   addr        register pointer
//   wen         one-clk write strobe, qualifies wdata/addr
//   wdata       last received data byte
//   rdata_used  one-clk pulse when rdata is loaded into the TX shifter
//   rdata       read data for addr (may be combinational from addr)
//   dbg_state   current protocol FSM state (encoding below)
//
// Strobe semantics: wen and rdata_used are single-cycle pulses with no
// back-pressure. The peripheral must accept a write in the cycle wen is high
// (addr and wdata are stable in that cycle) and must present rdata for the
// current addr at all times; the sample is taken on the SCL fall that
// produces rdata_used, and addr advances on the following clock.
// -----------------------------------------------------------------------------
module i2c_target_core #(
  parameter logic [6:0] TARGET_ADDR = 7'h70,
  parameter int         AUTO_INC    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic       rw,
  output logic [7:0] addr,
  output logic       wen,
  output logic [7:0] wdata,
  output logic       rdata_used,
  input  logic [7:0] rdata,
  output logic [3:0] dbg_state
);

  // FSM encoding, also visible on dbg_state.
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RD_ACKCHK = 4'd8;
  localparam logic [3:0] WAIT_STOP = 4'd9;

  localparam bit INC_EN = (AUTO_INC != 0);

  // ---------------------------------------------------------------------------
  // Input synchroniser: two flops per pin plus one history flop. Every edge
  // and condition below is derived from synchronised values only, so the
  // decode lags the pins by three clocks.
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;

  // Reset to the idle-bus level so that leaving reset while the bus is idle
  // creates no spurious edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise =  scl_s & ~scl_d;
  assign scl_fall = ~scl_s &  scl_d;
  // SCL must be high on both the current and the history sample, so an SDA
  // change that races an SCL edge is never taken for a bus condition.
  assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  logic [3:0] state;
  logic [3:0] bit_cnt;   // SCL rises seen in the current byte (9 = ACK seen)
  logic [7:0] rx_shift;  // receive shifter, MSB first
  logic [6:0] tx_rest;   // bits still to send after the one on the bus

  assign sda_o     = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      rx_shift   <= 8'h00;
      tx_rest    <= 7'h00;
      sda_oe     <= 1'b0;
      rw         <= 1'b0;
      addr       <= 8'h00;
      wen        <= 1'b0;
      wdata      <= 8'h00;
      rdata_used <= 1'b0;
    end else begin
      wen        <= 1'b0;
      rdata_used <= 1'b0;

      // Pointer advance one clock after a write strobe or a read load. A
      // pointer load can never fall on the same clock: byte events are whole
      // SCL periods apart.
      if (INC_EN && (wen || rdata_used)) begin
        addr <= addr + 8'd1;
      end

      if (start_det) begin
        // START or repeated START: restart address decode, keep addr.
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (scl_rise) begin
        // Bit sampling on SCL rise.
        case (state)
          ADDR, PTR, WDATA: begin
            if (bit_cnt < 4'd8) begin
              rx_shift <= {rx_shift[6:0], sda_s};
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          RDATA: begin
            if (bit_cnt < 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD_ACKCHK: begin
            // Controller's ACK/NACK after a read byte. A NACK ends the read.
            if (sda_s) begin
              state <= WAIT_STOP;
            end else begin
              bit_cnt <= 4'd9;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        // All SDA drive changes happen here, giving the controller the full
        // synchroniser delay of hold time after its SCL fall.
        case (state)
          ADDR: begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (rx_shift[7:1] == TARGET_ADDR) begin
                rw     <= rx_shift[0];
                sda_oe <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
                state  <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            // This fall ends the ACK clock.
            bit_cnt <= 4'd0;
            if (rw) begin
              tx_rest    <= rdata[6:0];
              sda_oe     <= ~rdata[7];
              rdata_used <= 1'b1;
              state      <= RDATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= PTR;
            end
          end
          PTR: begin
            if (bit_cnt == 4'd8) begin
              addr    <= rx_shift;
              sda_oe  <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            state   <= WDATA;
          end
          WDATA: begin
            if (bit_cnt == 4'd8) begin
              wdata   <= rx_shift;
              wen     <= 1'b1;
              sda_oe  <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            state   <= WDATA;
          end
          RDATA: begin
            if (bit_cnt == 4'd8) begin
              // Byte done: release SDA for the controller's ACK. bit_cnt is
              // left at 8 so the ACK rise can mark it as 9.
              sda_oe <= 1'b0;
              state  <= RD_ACKCHK;
            end else begin
              sda_oe  <= ~tx_rest[6];
              tx_rest <= {tx_rest[5:0], 1'b0};
            end
          end
          RD_ACKCHK: begin
            if (bit_cnt == 4'd9) begin
              tx_rest    <= rdata[6:0];
              sda_oe     <= ~rdata[7];
              rdata_used <= 1'b1;
              bit_cnt    <= 4'd0;
              state      <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
